// File: rtl/pulse_gen_pkg.sv
// Shared types for the periodic pulse source: FSM states, config record, validity rule.
// Config fields are held at PG_CFG_W bits; narrower counters use the low bits.
// The validity rule lives here so every user of pulse_cfg_t agrees on it.
package pulse_gen_pkg;

  localparam int unsigned PG_MIN_PERIOD = 4;
  localparam int unsigned PG_CFG_W      = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } pulse_gen_state_t;

  typedef struct packed {
    logic [PG_CFG_W-1:0] period;
    logic [PG_CFG_W-1:0] high;
  } pulse_cfg_t;

  // A period must be long enough and contain at least one high and one low cycle.
  function automatic logic cfg_is_valid(input logic [PG_CFG_W-1:0] period,
                                        input logic [PG_CFG_W-1:0] high,
                                        input logic [PG_CFG_W-1:0] min_period);
    return (period >= min_period) && (high != '0) && (high < period);
  endfunction

endpackage

// File: rtl/pulse_gen_cfg_buf.sv
// Config intake: valid/ready handshake, validity check, one-entry shadow, sticky error.
// Latency: accepted config visible on shadow_o the cycle after the handshake.
// Backpressure: cfg_ready_o low while the shadow holds a config not yet loaded.
module pulse_gen_cfg_buf
  import pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned MIN_PERIOD = PG_MIN_PERIOD
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [CNT_WIDTH-1:0] period_i,
  input  logic [CNT_WIDTH-1:0] high_i,
  input  logic                 load_i,
  output pulse_cfg_t           shadow_o,
  output logic                 shadow_vld_o,
  output logic                 err_o
);

  pulse_cfg_t shadow_q, shadow_d;
  logic       shadow_vld_q, shadow_vld_d;
  logic       err_q, err_d;
  logic       hs;
  logic       cfg_ok;

  // Accept or reject offered configs; a load empties the shadow.
  // Handshake and load never coincide: a load needs a full shadow, which blocks ready.
  always_comb begin
    hs           = cfg_valid_i & ~shadow_vld_q;
    cfg_ok       = cfg_is_valid(PG_CFG_W'(period_i), PG_CFG_W'(high_i),
                                PG_CFG_W'(MIN_PERIOD));
    shadow_d     = shadow_q;
    shadow_vld_d = shadow_vld_q;
    err_d        = err_q;
    if (load_i) begin
      shadow_vld_d = 1'b0;
    end
    if (hs) begin
      if (cfg_ok) begin
        shadow_d.period = PG_CFG_W'(period_i);
        shadow_d.high   = PG_CFG_W'(high_i);
        shadow_vld_d    = 1'b1;
        err_d           = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Shadow and error state registers.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      shadow_vld_q <= shadow_vld_d;
      err_q        <= err_d;
    end
  end

  assign cfg_ready_o  = ~shadow_vld_q;
  assign shadow_o     = shadow_q;
  assign shadow_vld_o = shadow_vld_q;
  assign err_o        = err_q;

endmodule

// File: rtl/pulse_gen.sv
// Programmable periodic pulse source; config swapped only at period boundaries.
// Latency: en_i sampled in IDLE at T gives sig_o=1 (cnt=0) at T+1.
// Backpressure: cfg_ready_o low until the shadowed config is loaded at a boundary.
module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned MIN_PERIOD     = PG_MIN_PERIOD,
  parameter int unsigned EDGE_CNT_WIDTH = 16
) (
  input  logic                      clk_i,
  input  logic                      arst_i,
  input  logic                      en_i,
  input  logic                      cfg_valid_i,
  output logic                      cfg_ready_o,
  input  logic [CNT_WIDTH-1:0]      period_i,
  input  logic [CNT_WIDTH-1:0]      high_i,
  output logic                      sig_o,
  output logic                      run_o,
  output logic                      err_o,
  output logic [EDGE_CNT_WIDTH-1:0] edge_cnt_o
);

  pulse_gen_state_t          state_q, state_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic                      sig_q, sig_d;
  logic [EDGE_CNT_WIDTH-1:0] edge_q, edge_d;
  pulse_cfg_t                act_q, act_d;
  logic                      act_vld_q, act_vld_d;

  pulse_cfg_t                shadow;
  logic                      shadow_vld;
  logic                      load;
  logic                      wrap;

  pulse_gen_cfg_buf #(
    .CNT_WIDTH  (CNT_WIDTH),
    .MIN_PERIOD (MIN_PERIOD)
  ) u_cfg_buf (
    .clk_i        (clk_i),
    .arst_i       (arst_i),
    .cfg_valid_i  (cfg_valid_i),
    .cfg_ready_o  (cfg_ready_o),
    .period_i     (period_i),
    .high_i       (high_i),
    .load_i       (load),
    .shadow_o     (shadow),
    .shadow_vld_o (shadow_vld),
    .err_o        (err_o)
  );

  // Next state, counter and output level. sig_d is taken from the next count
  // against the config that will be active then, so a period never mixes configs.
  always_comb begin
    wrap      = (cnt_q == CNT_WIDTH'(act_q.period - PG_CFG_W'(1)));
    load      = shadow_vld & ((state_q == IDLE) | wrap);
    state_d   = state_q;
    cnt_d     = cnt_q;
    sig_d     = sig_q;
    act_d     = act_q;
    act_vld_d = act_vld_q;
    if (load) begin
      act_d     = shadow;
      act_vld_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        sig_d = 1'b0;
        if (en_i & act_vld_q) begin
          state_d = RUN;
          sig_d   = (act_d.high != '0);
        end
      end
      RUN, STOPPING: begin
        cnt_d = wrap ? '0 : cnt_q + CNT_WIDTH'(1);
        sig_d = (cnt_d < CNT_WIDTH'(act_d.high));
        if (state_q == RUN) begin
          if (!en_i) state_d = STOPPING;
        end else if (en_i) begin
          state_d = RUN;
        end else if (wrap) begin
          state_d = IDLE;
          cnt_d   = '0;
          sig_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        sig_d   = 1'b0;
      end
    endcase
    edge_d = edge_q + EDGE_CNT_WIDTH'(sig_d & ~sig_q);
  end

  // FSM, counter, active config and registered outputs.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sig_q     <= 1'b0;
      edge_q    <= '0;
      act_q     <= '0;
      act_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sig_q     <= sig_d;
      edge_q    <= edge_d;
      act_q     <= act_d;
      act_vld_q <= act_vld_d;
    end
  end

  assign sig_o      = sig_q;
  assign run_o      = (state_q != IDLE);
  assign edge_cnt_o = edge_q;

endmodule

// File: tb/tb_pulse_gen.sv
// Directed bench for pulse_gen; edge counter narrowed to 4 bits to reach the wrap.
// Inputs are driven and outputs sampled 1 time unit after each rising clock edge.
// Each scenario task checks its own expectations inline.
module tb_pulse_gen;

  localparam int CW = 32;
  localparam int EW = 4;

  logic          clk_i = 1'b0;
  logic          arst_i;
  logic          en_i;
  logic          cfg_valid_i;
  logic          cfg_ready_o;
  logic [CW-1:0] period_i;
  logic [CW-1:0] high_i;
  logic          sig_o;
  logic          run_o;
  logic          err_o;
  logic [EW-1:0] edge_cnt_o;

  int checks   = 0;
  int failures = 0;

  pulse_gen #(
    .CNT_WIDTH      (CW),
    .MIN_PERIOD     (4),
    .EDGE_CNT_WIDTH (EW)
  ) dut (
    .clk_i       (clk_i),
    .arst_i      (arst_i),
    .en_i        (en_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ready_o (cfg_ready_o),
    .period_i    (period_i),
    .high_i      (high_i),
    .sig_o       (sig_o),
    .run_o       (run_o),
    .err_o       (err_o),
    .edge_cnt_o  (edge_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    arst_i      = 1'b1;
    en_i        = 1'b0;
    cfg_valid_i = 1'b0;
    period_i    = '0;
    high_i      = '0;
    #12;
    arst_i = 1'b0;
    tick();
  endtask

  // Offer a config and wait until it is active (IDLE loads it the cycle after acceptance).
  task automatic load_cfg(input int p, input int h);
    period_i    = CW'(p);
    high_i      = CW'(h);
    cfg_valid_i = 1'b1;
    tick();
    cfg_valid_i = 1'b0;
    tick();
    tick();
  endtask

  // en_i sampled at the next edge; on return the generator is at cnt=0.
  task automatic start_run();
    en_i = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (sig_o !== 1'b0 || run_o !== 1'b0 || err_o !== 1'b0 ||
        cfg_ready_o !== 1'b1 || edge_cnt_o !== '0) begin
      failures++;
      $display("FAIL reset_values: sig=%b run=%b err=%b rdy=%b edge=%0d, want 0 0 0 1 0",
               sig_o, run_o, err_o, cfg_ready_o, edge_cnt_o);
    end
  endtask

  task automatic test_basic();
    logic exp;
    do_reset();
    period_i = 10; high_i = 3; cfg_valid_i = 1'b1;
    tick();
    cfg_valid_i = 1'b0;
    checks++;
    if (cfg_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_rdy_after_accept: got %b want 0", cfg_ready_o);
    end
    tick();
    tick();
    checks++;
    if (cfg_ready_o !== 1'b1 || run_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_rdy_after_load: rdy=%b run=%b want 1 0", cfg_ready_o, run_o);
    end
    start_run();
    for (int k = 0; k < 50; k++) begin
      if (k > 0) tick();
      exp = ((k % 10) < 3);
      checks++;
      if (sig_o !== exp || run_o !== 1'b1) begin
        failures++;
        $display("FAIL basic_wave k=%0d: sig=%b run=%b want %b 1", k, sig_o, run_o, exp);
      end
    end
    checks++;
    if (edge_cnt_o !== EW'(5)) begin
      failures++;
      $display("FAIL basic_edge_cnt: got %0d want 5", edge_cnt_o);
    end
    en_i = 1'b0;
  endtask

  task automatic test_invalid();
    do_reset();
    period_i = 2; high_i = 1; cfg_valid_i = 1'b1;
    tick();
    cfg_valid_i = 1'b0;
    checks++;
    if (err_o !== 1'b1 || cfg_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL inv_short_period: err=%b rdy=%b want 1 1", err_o, cfg_ready_o);
    end
    en_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (sig_o !== 1'b0 || run_o !== 1'b0) begin
        failures++;
        $display("FAIL inv_stays_idle k=%0d: sig=%b run=%b want 0 0", k, sig_o, run_o);
      end
    end
    en_i = 1'b0;
    // Smallest legal period with the largest legal high time clears the error.
    period_i = 4; high_i = 3; cfg_valid_i = 1'b1;
    tick();
    cfg_valid_i = 1'b0;
    checks++;
    if (err_o !== 1'b0 || cfg_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL inv_min_ok: err=%b rdy=%b want 0 0", err_o, cfg_ready_o);
    end
    tick();
    tick();
    period_i = 8; high_i = 8; cfg_valid_i = 1'b1;
    tick();
    cfg_valid_i = 1'b0;
    checks++;
    if (err_o !== 1'b1 || cfg_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL inv_high_eq_period: err=%b rdy=%b want 1 1", err_o, cfg_ready_o);
    end
    period_i = 5; high_i = 0; cfg_valid_i = 1'b1;
    tick();
    cfg_valid_i = 1'b0;
    checks++;
    if (err_o !== 1'b1 || cfg_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL inv_high_zero: err=%b rdy=%b want 1 1", err_o, cfg_ready_o);
    end
  endtask

  // Reconfigure 10/3 -> 6/2 with the offer accepted at cycle acc_k.
  // New config applies at the first boundary strictly after acceptance.
  task automatic test_reconfig(input int acc_k, input int swap_k, input int n);
    logic exp_sig;
    logic exp_rdy;
    do_reset();
    load_cfg(10, 3);
    start_run();
    for (int k = 0; k < n; k++) begin
      if (k > 0) tick();
      if (k == acc_k) cfg_valid_i = 1'b0;
      exp_sig = (k < swap_k) ? ((k % 10) < 3) : (((k - swap_k) % 6) < 2);
      exp_rdy = !(k >= acc_k && k < swap_k);
      checks++;
      if (sig_o !== exp_sig || cfg_ready_o !== exp_rdy) begin
        failures++;
        $display("FAIL reconfig_acc%0d k=%0d: sig=%b rdy=%b want %b %b",
                 acc_k, k, sig_o, cfg_ready_o, exp_sig, exp_rdy);
      end
      if (k == acc_k - 1) begin
        period_i = 6; high_i = 2; cfg_valid_i = 1'b1;
      end
    end
    en_i = 1'b0;
  endtask

  task automatic test_stop();
    logic exp_sig;
    logic exp_run;
    do_reset();
    load_cfg(10, 3);
    start_run();
    for (int k = 0; k < 15; k++) begin
      if (k > 0) tick();
      exp_run = (k < 10);
      exp_sig = exp_run && ((k % 10) < 3);
      checks++;
      if (sig_o !== exp_sig || run_o !== exp_run) begin
        failures++;
        $display("FAIL stop_mid k=%0d: sig=%b run=%b want %b %b", k, sig_o, run_o, exp_sig, exp_run);
      end
      if (k == 4) en_i = 1'b0;
    end
    start_run();
    for (int k = 0; k < 30; k++) begin
      if (k > 0) tick();
      exp_sig = ((k % 10) < 3);
      checks++;
      if (sig_o !== exp_sig || run_o !== 1'b1) begin
        failures++;
        $display("FAIL stop_resume k=%0d: sig=%b run=%b want %b 1", k, sig_o, run_o, exp_sig);
      end
      if (k == 4) en_i = 1'b0;
      if (k == 7) en_i = 1'b1;
    end
    // en_i dropping on the boundary cycle costs one more full period.
    en_i = 1'b0;
    do_reset();
    load_cfg(10, 3);
    start_run();
    for (int k = 0; k < 25; k++) begin
      if (k > 0) tick();
      exp_run = (k < 20);
      exp_sig = exp_run && ((k % 10) < 3);
      checks++;
      if (sig_o !== exp_sig || run_o !== exp_run) begin
        failures++;
        $display("FAIL stop_boundary k=%0d: sig=%b run=%b want %b %b", k, sig_o, run_o, exp_sig, exp_run);
      end
      if (k == 9) en_i = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    load_cfg(10, 3);
    start_run();
    tick();
    checks++;
    if (sig_o !== 1'b1) begin
      failures++;
      $display("FAIL arst_pre_high: sig=%b want 1", sig_o);
    end
    arst_i = 1'b1;
    #1;
    checks++;
    if (sig_o !== 1'b0 || edge_cnt_o !== '0 || run_o !== 1'b0) begin
      failures++;
      $display("FAIL arst_immediate: sig=%b edge=%0d run=%b want 0 0 0", sig_o, edge_cnt_o, run_o);
    end
    #3;
    arst_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (sig_o !== 1'b0 || run_o !== 1'b0) begin
        failures++;
        $display("FAIL arst_cfg_lost k=%0d: sig=%b run=%b want 0 0", k, sig_o, run_o);
      end
    end
    period_i = 10; high_i = 3; cfg_valid_i = 1'b1;
    tick();
    cfg_valid_i = 1'b0;
    tick();
    checks++;
    if (run_o !== 1'b0) begin
      failures++;
      $display("FAIL arst_restart_early: run=%b want 0", run_o);
    end
    tick();
    checks++;
    if (run_o !== 1'b1 || sig_o !== 1'b1 || edge_cnt_o !== EW'(1)) begin
      failures++;
      $display("FAIL arst_restart: run=%b sig=%b edge=%0d want 1 1 1", run_o, sig_o, edge_cnt_o);
    end
    en_i = 1'b0;
  endtask

  task automatic test_min_wrap();
    logic exp;
    do_reset();
    load_cfg(4, 1);
    start_run();
    for (int k = 0; k < 65; k++) begin
      if (k > 0) tick();
      exp = ((k % 4) == 0);
      checks++;
      if (sig_o !== exp) begin
        failures++;
        $display("FAIL min_wave k=%0d: sig=%b want %b", k, sig_o, exp);
      end
      if (k == 63) begin
        checks++;
        if (edge_cnt_o !== EW'(0)) begin
          failures++;
          $display("FAIL edge_wrap_16: got %0d want 0", edge_cnt_o);
        end
      end
    end
    checks++;
    if (edge_cnt_o !== EW'(1)) begin
      failures++;
      $display("FAIL edge_wrap_17: got %0d want 1", edge_cnt_o);
    end
    en_i = 1'b0;
  endtask

  // Measure the waveform the way a downstream period meter would.
  task automatic test_measure();
    logic prev;
    int   rise1;
    int   rise2;
    int   high_cnt;
    do_reset();
    load_cfg(100, 50);
    start_run();
    prev     = sig_o;
    rise1    = -1;
    rise2    = -1;
    high_cnt = sig_o ? 1 : 0;
    for (int k = 1; k <= 250 && rise2 < 0; k++) begin
      tick();
      if (sig_o && !prev) begin
        if (rise1 < 0) rise1 = k;
        else           rise2 = k;
      end
      if (sig_o && rise1 < 0) high_cnt++;
      prev = sig_o;
    end
    checks++;
    if (rise1 != 100) begin
      failures++;
      $display("FAIL meas_period1: got %0d want 100", rise1);
    end
    checks++;
    if (rise2 - rise1 != 100) begin
      failures++;
      $display("FAIL meas_period2: got %0d want 100", rise2 - rise1);
    end
    checks++;
    if (high_cnt != 50) begin
      failures++;
      $display("FAIL meas_high: got %0d want 50", high_cnt);
    end
    en_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_invalid();
    test_reconfig(5, 10, 28);
    test_reconfig(10, 20, 32);
    test_stop();
    test_async_reset();
    test_min_wrap();
    test_measure();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_gen.md
Name: pulse_gen

Overview:
- Programmable periodic pulse source for the measure unit.
- It is the transmitter side of the period-measurement / strobe-generation path: it drives a signal of known period and high time, which the strobe generator then measures and locks to.
- Used for calibration loopback and as a stimulus source for the comparator path.
- Configuration is shadowed and swapped only at period boundaries, so the output never contains a truncated period.

Parameters:
- CNT_WIDTH, 32, width of period, high-time and period counter.
- MIN_PERIOD, 4, smallest accepted period in clk_i cycles.
- EDGE_CNT_WIDTH, 16, width of the emitted-edge counter.

Ports:
- clk_i  in  1  clock.
- arst_i  in  1  reset, asynchronous, active-high.
- en_i  in  1  run request, level-sensitive.
- cfg_valid_i  in  1  new configuration offered.
- cfg_ready_o  out  1  shadow register empty; configuration may be accepted.
- period_i  in  CNT_WIDTH  period in cycles, sampled on handshake.
- high_i  in  CNT_WIDTH  high time in cycles, sampled on handshake.
- sig_o  out  1  generated signal, registered.
- run_o  out  1  generator in RUN or STOPPING.
- err_o  out  1  sticky: last offered configuration was invalid.
- edge_cnt_o  out  EDGE_CNT_WIDTH  number of rising edges emitted; wraps.

Behaviour:
- Reset and clock: reset arst_i, asynchronous, active-high; clock clk_i.
- Reset values:
  - sig_o=0, run_o=0, err_o=0, cfg_ready_o=1, edge_cnt_o=0.
  - state=IDLE, active config cleared (act_valid=0), shadow empty, counter cnt=0.
- Config handshake:
  - A transfer occurs when cfg_valid_i & cfg_ready_o.
  - The config is valid iff period_i >= MIN_PERIOD and 1 <= high_i < period_i.
  - Valid config: stored in the shadow; err_o cleared; cfg_ready_o=0 the next cycle until the shadow is consumed.
  - Invalid config: discarded; err_o=1 the next cycle; shadow unchanged; cfg_ready_o unchanged.
- Shadow to active transfer:
  - In IDLE: the cycle after acceptance; sets act_valid=1.
  - In RUN or STOPPING: on the cycle with cnt == period_act-1, so the following period uses the new values.
  - cfg_ready_o returns to 1 the cycle after the transfer.
- States:
  - IDLE: sig_o=0, cnt held at 0. Go to RUN when en_i & act_valid. If act_valid=0, stay in IDLE; no error is raised.
  - RUN: cnt counts 0..period_act-1 then wraps to 0. sig_o=1 exactly when cnt < high_act. Go to STOPPING when en_i=0.
  - STOPPING: keeps counting and driving as in RUN. If en_i=1, return to RUN with no glitch and no phase change. At cnt == period_act-1, go to IDLE; sig_o=0 from the next cycle.
- Start latency: en_i sampled high in IDLE at cycle T → state RUN, cnt=0 and sig_o=1 at T+1.
- Outputs:
  - sig_o is registered and derived from next-state counter values; no combinational path from inputs.
  - edge_cnt_o increments in the same cycle sig_o goes 0→1; it wraps modulo 2^EDGE_CNT_WIDTH.
  - run_o=1 in RUN and STOPPING.
- Arithmetic: unsigned compares only; cnt never exceeds period_act-1.
- Simultaneous events:
  - Handshake on the same cycle as a boundary: the new config goes to the shadow and applies at the next boundary, not the current one.
  - en_i falling on the boundary cycle: the generator finishes the following period, i.e. one extra complete period.
- Reset mid-operation: sig_o drops asynchronously; the active config is lost.

Decomposition:
- Package pulse_gen_pkg holds:
  - state enum pulse_gen_state_t {IDLE, RUN, STOPPING}, logic[1:0];
  - the MIN_PERIOD default constant;
  - the config struct {period, high}.
- Sub-module pulse_gen_cfg_buf holds:
  - the valid/ready handshake, validity check, shadow register and err_o;
  - a load strobe from the parent that moves shadow → active.
- The parent holds the FSM, counter and output register.

Test Plan:
1. Reset, then config period=10 high=3, en_i=1 → first rise 1 cycle after the start sample; sig_o high 3 cycles, low 7; rises every 10 cycles; edge_cnt_o=5 after 5 periods.
2. Config period=2 high=1 (< MIN_PERIOD), then period=8 high=8 → err_o=1 after each; cfg_ready_o stays 1; en_i keeps the generator in IDLE with sig_o=0.
3. Running at 10/3, offer 6/2 mid-period → current period completes as 10/3; the next period is exactly 6/2; cfg_ready_o low from the cycle after acceptance until the cycle after the boundary.
4. Running, en_i low at cnt=4 → period completes, then sig_o=0 and run_o=0. Repeat with en_i re-asserted at cnt=7 → uninterrupted 10-cycle periods.
5. arst_i pulse at cnt=1 (sig_o high) → sig_o=0 immediately; edge_cnt_o=0; en_i=1 after release stays IDLE until a new config arrives.
6. Loopback sig_o into stb_gen sig_i with period=100 high=50 → stb_gen stb_period_o==100 and rdy_o=1.
